// File: rtl/mux32_32x1_reg_pkg.sv
// ---------------------------------------------------------------------------
// mux32_32x1_reg_pkg
// Shared definitions for the registered 32-to-1 word multiplexer.
//   DATA_INDEX_LIMIT : index of the most significant data bit
//   DATA_WIDTH       : width of every data word
//   SEL_WIDTH        : select width; the tree has 2**SEL_WIDTH leaves
//   tree_level_base  : first slot of a tree level in the flat node array
// ---------------------------------------------------------------------------
package mux32_32x1_reg_pkg;

  localparam int DATA_INDEX_LIMIT = 31;
  localparam int DATA_WIDTH       = DATA_INDEX_LIMIT + 1;
  localparam int SEL_WIDTH        = 5;
  localparam int NUM_INPUTS       = 2 ** SEL_WIDTH;

  // Nodes are stored level by level: level 0 holds the 32 input words,
  // level 1 the 16 leaf-mux outputs, and so on up to the single root at
  // level SEL_WIDTH. Level k starts at 2*N - (2*N >> k).
  function automatic int tree_level_base(input int num_leaves, input int level);
    return (2 * num_leaves) - ((2 * num_leaves) >> level);
  endfunction

endpackage

// File: rtl/mux32_2x1.sv
// ---------------------------------------------------------------------------
// mux32_2x1
// Two-input word multiplexer used as the building block of the select tree.
//   I0 : input  [DATA_WIDTH-1:0]  word passed when S = 0
//   I1 : input  [DATA_WIDTH-1:0]  word passed when S = 1
//   S  : input                    select
//   Y  : output [DATA_WIDTH-1:0]  selected word (combinational)
// ---------------------------------------------------------------------------
module mux32_2x1
  import mux32_32x1_reg_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic             S,
  output logic [WIDTH-1:0] Y
);

  assign Y = S ? I1 : I0;

endmodule

// File: rtl/mux32_32x1_reg.sv
// ---------------------------------------------------------------------------
// mux32_32x1_reg
// Registered 32-bit, 32-to-1 multiplexer. A five-level tree of 2:1 word
// muxes selects I[S]; the result is captured in a single output register,
// so Y reflects the inputs sampled at the previous rising edge.
//   CLK     : input                     system clock, rising edge
//   RST     : input                     synchronous active-high reset (Y <= 0)
//   S       : input  [SEL_WIDTH-1:0]    select, S = n picks In
//   I0..I31 : input  [DATA_WIDTH-1:0]   data words
//   Y       : output [DATA_WIDTH-1:0]   registered selected word
// ---------------------------------------------------------------------------
module mux32_32x1_reg
  import mux32_32x1_reg_pkg::*;
#(
  parameter int DATA_WIDTH = mux32_32x1_reg_pkg::DATA_WIDTH,
  parameter int SEL_WIDTH  = mux32_32x1_reg_pkg::SEL_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [SEL_WIDTH-1:0]  S,
  input  logic [DATA_WIDTH-1:0] I0,  I1,  I2,  I3,  I4,  I5,  I6,  I7,
  input  logic [DATA_WIDTH-1:0] I8,  I9,  I10, I11, I12, I13, I14, I15,
  input  logic [DATA_WIDTH-1:0] I16, I17, I18, I19, I20, I21, I22, I23,
  input  logic [DATA_WIDTH-1:0] I24, I25, I26, I27, I28, I29, I30, I31,
  output logic [DATA_WIDTH-1:0] Y
);

  localparam int LEAVES     = 2 ** SEL_WIDTH;
  localparam int NODE_COUNT = 2 * LEAVES - 1;
  localparam int ROOT       = NODE_COUNT - 1;

  logic [DATA_WIDTH-1:0] node [NODE_COUNT];
  logic [DATA_WIDTH-1:0] y_d;
  logic [DATA_WIDTH-1:0] y_q;

  // Level 0 of the tree is the raw input words in select order.
  assign node[0]  = I0;   assign node[1]  = I1;
  assign node[2]  = I2;   assign node[3]  = I3;
  assign node[4]  = I4;   assign node[5]  = I5;
  assign node[6]  = I6;   assign node[7]  = I7;
  assign node[8]  = I8;   assign node[9]  = I9;
  assign node[10] = I10;  assign node[11] = I11;
  assign node[12] = I12;  assign node[13] = I13;
  assign node[14] = I14;  assign node[15] = I15;
  assign node[16] = I16;  assign node[17] = I17;
  assign node[18] = I18;  assign node[19] = I19;
  assign node[20] = I20;  assign node[21] = I21;
  assign node[22] = I22;  assign node[23] = I23;
  assign node[24] = I24;  assign node[25] = I25;
  assign node[26] = I26;  assign node[27] = I27;
  assign node[28] = I28;  assign node[29] = I29;
  assign node[30] = I30;  assign node[31] = I31;

  // Each level halves the candidate set using one select bit, LSB first,
  // so pair (2j, 2j+1) at level k is resolved by S[k] and the root by the MSB.
  for (genvar lvl = 0; lvl < SEL_WIDTH; lvl++) begin : g_level
    localparam int SRC_BASE = tree_level_base(LEAVES, lvl);
    localparam int DST_BASE = tree_level_base(LEAVES, lvl + 1);
    for (genvar j = 0; j < (LEAVES >> (lvl + 1)); j++) begin : g_mux
      mux32_2x1 #(
        .WIDTH(DATA_WIDTH)
      ) u_mux (
        .I0(node[SRC_BASE + 2 * j]),
        .I1(node[SRC_BASE + 2 * j + 1]),
        .S (S[lvl]),
        .Y (node[DST_BASE + j])
      );
    end
  end

  // The tree root is the only thing the output register ever sees.
  always_comb begin
    y_d = node[ROOT];
  end

  // Output register; reset wins over any data or select activity.
  always_ff @(posedge CLK) begin
    if (RST) begin
      y_q <= '0;
    end else begin
      y_q <= y_d;
    end
  end

  assign Y = y_q;

endmodule

// File: tb/tb_mux32_32x1_reg.sv
// ---------------------------------------------------------------------------
// tb_mux32_32x1_reg
// Directed bench for the registered 32-to-1 word multiplexer. Inputs are
// changed between edges and Y is sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_mux32_32x1_reg;

  logic        clk;
  logic        rst;
  logic [4:0]  sel;
  logic [31:0] iw [32];
  logic [31:0] y;

  int total;
  int bad;

  // Hand-written words for I8..I31 (index 0 of this table is I8).
  logic [31:0] sweep_words [24];

  mux32_32x1_reg dut (
    .CLK(clk), .RST(rst), .S(sel),
    .I0 (iw[0]),  .I1 (iw[1]),  .I2 (iw[2]),  .I3 (iw[3]),
    .I4 (iw[4]),  .I5 (iw[5]),  .I6 (iw[6]),  .I7 (iw[7]),
    .I8 (iw[8]),  .I9 (iw[9]),  .I10(iw[10]), .I11(iw[11]),
    .I12(iw[12]), .I13(iw[13]), .I14(iw[14]), .I15(iw[15]),
    .I16(iw[16]), .I17(iw[17]), .I18(iw[18]), .I19(iw[19]),
    .I20(iw[20]), .I21(iw[21]), .I22(iw[22]), .I23(iw[23]),
    .I24(iw[24]), .I25(iw[25]), .I26(iw[26]), .I27(iw[27]),
    .I28(iw[28]), .I29(iw[29]), .I30(iw[30]), .I31(iw[31]),
    .Y(y)
  );

  // 10-unit clock period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Set the select and one data word; inputs move only between edges.
  task automatic applyStimulus(input logic [4:0] s_val, input int idx, input logic [31:0] data);
    sel     = s_val;
    iw[idx] = data;
  endtask

  // Advance past the next rising edge and settle before sampling.
  task automatic clockEdge();
    @(posedge clk);
    #1;
  endtask

  // Compare Y to the value the bench expects at this point.
  task automatic checkOutput(input string tag, input logic [31:0] expected);
    total++;
    assert (y === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, y, expected);
    end
  endtask

  // Directed sequence: reset, low selects, data-only change, full sweep with
  // mid-stream reset, then a simultaneous select/data change.
  initial begin
    total = 0;
    bad   = 0;

    sweep_words[0]  = 32'h88888888;  sweep_words[1]  = 32'h99999999;
    sweep_words[2]  = 32'hAAAA1010;  sweep_words[3]  = 32'hBBBB1111;
    sweep_words[4]  = 32'hCCCC1212;  sweep_words[5]  = 32'hDDDD1313;
    sweep_words[6]  = 32'hEEEE1414;  sweep_words[7]  = 32'hFFFF1515;
    sweep_words[8]  = 32'h16161616;  sweep_words[9]  = 32'h17171717;
    sweep_words[10] = 32'h18181818;  sweep_words[11] = 32'h19191919;
    sweep_words[12] = 32'h20202020;  sweep_words[13] = 32'h21212121;
    sweep_words[14] = 32'h22222222;  sweep_words[15] = 32'h23232323;
    sweep_words[16] = 32'h24242424;  sweep_words[17] = 32'h25252525;
    sweep_words[18] = 32'h26262626;  sweep_words[19] = 32'h27272727;
    sweep_words[20] = 32'h28282828;  sweep_words[21] = 32'h29292929;
    sweep_words[22] = 32'h30303030;  sweep_words[23] = 32'h31313131;

    for (int n = 0; n < 32; n++) iw[n] = 32'h0;
    rst = 1'b1;
    applyStimulus(5'd0, 0, 32'h00012340);

    // Reset held for two edges.
    clockEdge();
    checkOutput("reset_edge1", 32'h00000000);
    clockEdge();
    checkOutput("reset_edge2", 32'h00000000);

    // Release reset: first edge loads I0.
    rst = 1'b0;
    #1;
    checkOutput("reset_release_hold", 32'h00000000);
    clockEdge();
    checkOutput("reset_release_load", 32'h00012340);

    // Low selects, each visible one edge after it is applied.
    applyStimulus(5'd1, 1, 32'hFFFFFFFF);
    #1;
    checkOutput("s1_before_edge", 32'h00012340);
    clockEdge();
    checkOutput("s1", 32'hFFFFFFFF);
    applyStimulus(5'd2, 2, 32'h0000ADE0);
    #1;
    checkOutput("s2_before_edge", 32'hFFFFFFFF);
    clockEdge();
    checkOutput("s2", 32'h0000ADE0);
    applyStimulus(5'd3, 3, 32'hACDEFB00);
    clockEdge();
    checkOutput("s3", 32'hACDEFB00);

    // Data change on the selected input without a select change.
    applyStimulus(5'd4, 4, 32'h44444444);
    clockEdge();
    checkOutput("s4_initial", 32'h44444444);
    applyStimulus(5'd4, 4, 32'h12345678);
    #2;
    checkOutput("s4_between_edges", 32'h44444444);
    clockEdge();
    checkOutput("s4_updated", 32'h12345678);
    applyStimulus(5'd4, 5, 32'hDEADBEEF);
    clockEdge();
    checkOutput("s4_unselected_change", 32'h12345678);

    // Full sweep of S = 8..27 across the root boundary at 15/16.
    for (int n = 8; n < 32; n++) iw[n] = sweep_words[n - 8];
    for (int n = 8; n <= 27; n++) begin
      sel = 5'(n);
      clockEdge();
      checkOutput($sformatf("sweep_s%0d", n), sweep_words[n - 8]);
    end

    // Reset mid-stream for one edge, then resume at S=28 with no dead cycle.
    rst = 1'b1;
    clockEdge();
    checkOutput("midstream_reset", 32'h00000000);
    rst = 1'b0;
    sel = 5'd28;
    clockEdge();
    checkOutput("post_reset_s28", 32'h28282828);
    for (int n = 29; n <= 31; n++) begin
      sel = 5'(n);
      clockEdge();
      checkOutput($sformatf("sweep_s%0d", n), sweep_words[n - 8]);
    end

    // Simultaneous select and selected-data change at one edge.
    applyStimulus(5'd0, 1, 32'h22330000);
    clockEdge();
    checkOutput("simul_pre_s0", 32'h00012340);
    applyStimulus(5'd1, 1, 32'hFFFFFFFF);
    clockEdge();
    checkOutput("simul_s1_new_data", 32'hFFFFFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
